// File: rtl/alu_bus_mdr_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_bus_mdr_if
// Description : Signal bundle for the shared-bus datapath core. It carries
//               the 24 bus sources and their drive selects, the ALU operand
//               and opcode, the MDR load controls and RAM data, and the bus,
//               MDR and 64-bit ALU result outputs.
// Ports       : master - drives sources/selects/controls, observes results
//               slave  - the datapath core (alu_bus_mdr)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_bus_mdr_if;
  logic [511:0] r_data;          // R0..R15, Rk at [32k+31:32k]
  logic [31:0]  hi_data;
  logic [31:0]  lo_data;
  logic [31:0]  zhigh_data;
  logic [31:0]  zlow_data;
  logic [31:0]  pc_data;
  logic [31:0]  inport_data;
  logic [31:0]  c_data;          // already sign-extended constant
  logic [15:0]  r_out;           // bit k drives Rk onto the bus
  logic [7:0]   src_sel;         // {C,InPort,MDR,PC,Zlow,Zhigh,LO,HI}out
  logic [31:0]  y_data;          // ALU operand A
  logic [4:0]   op;              // ALU opcode
  logic         MDRin;           // MDR load enable
  logic         Read;            // 1: load from MDataIn, 0: load from bus
  logic [31:0]  MDataIn;         // RAM read data
  logic [31:0]  BusMuxOut;
  logic [31:0]  BusMuxInMDRout;
  logic [31:0]  ZLowWire;
  logic [31:0]  ZHighWire;

  modport master (
    output r_data, hi_data, lo_data, zhigh_data, zlow_data, pc_data,
           inport_data, c_data, r_out, src_sel, y_data, op, MDRin, Read,
           MDataIn,
    input  BusMuxOut, BusMuxInMDRout, ZLowWire, ZHighWire
  );

  modport slave (
    input  r_data, hi_data, lo_data, zhigh_data, zlow_data, pc_data,
           inport_data, c_data, r_out, src_sel, y_data, op, MDRin, Read,
           MDataIn,
    output BusMuxOut, BusMuxInMDRout, ZLowWire, ZHighWire
  );
endinterface
`default_nettype wire

// File: rtl/alu_bus_mdr.sv
`default_nettype none
// ============================================================================
// Module      : alu_bus_mdr
// Description : Shared-bus core of the mini CPU datapath. A priority bus
//               multiplexer selects one of 24 sources onto BusMuxOut, a
//               combinational 32-bit ALU computes Y (op) BusMuxOut into a
//               64-bit Z result, and the memory data register (MDR) loads
//               from the bus or from RAM read data.
// Ports       : clock  - rising-edge clock
//               clear  - asynchronous active-high reset (clears the MDR)
//               bus_if - alu_bus_mdr_if.slave bundle (sources, selects,
//                        ALU operand/opcode, MDR controls, results)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bus_mdr (
  input  wire logic     clock,
  input  wire logic     clear,
  alu_bus_mdr_if.slave  bus_if
);

  // ALU opcodes
  localparam logic [4:0] c_op_ld   = 5'b00000;
  localparam logic [4:0] c_op_ldi  = 5'b00001;
  localparam logic [4:0] c_op_st   = 5'b00010;
  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_shr  = 5'b00101;
  localparam logic [4:0] c_op_shra = 5'b00110;
  localparam logic [4:0] c_op_shl  = 5'b00111;
  localparam logic [4:0] c_op_ror  = 5'b01000;
  localparam logic [4:0] c_op_rol  = 5'b01001;
  localparam logic [4:0] c_op_and  = 5'b01010;
  localparam logic [4:0] c_op_or   = 5'b01011;
  localparam logic [4:0] c_op_addi = 5'b01100;
  localparam logic [4:0] c_op_andi = 5'b01101;
  localparam logic [4:0] c_op_ori  = 5'b01110;
  localparam logic [4:0] c_op_mul  = 5'b01111;
  localparam logic [4:0] c_op_div  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_not  = 5'b10010;

  // src_sel bit positions
  localparam int c_sel_hi     = 0;
  localparam int c_sel_lo     = 1;
  localparam int c_sel_zhigh  = 2;
  localparam int c_sel_zlow   = 3;
  localparam int c_sel_pc     = 4;
  localparam int c_sel_mdr    = 5;
  localparam int c_sel_inport = 6;
  localparam int c_sel_c      = 7;

  logic [31:0] r_mdr;
  logic [31:0] w_bus;

  // --------------------------------------------------------------------------
  // Bus multiplexer. Sources are visited from lowest to highest priority so
  // that the last matching assignment (highest priority) wins. No select
  // asserted leaves the bus at zero.
  // --------------------------------------------------------------------------
  always_comb begin
    w_bus = 32'd0;
    if (bus_if.src_sel[c_sel_c])      w_bus = bus_if.c_data;
    if (bus_if.src_sel[c_sel_inport]) w_bus = bus_if.inport_data;
    if (bus_if.src_sel[c_sel_mdr])    w_bus = r_mdr;
    if (bus_if.src_sel[c_sel_pc])     w_bus = bus_if.pc_data;
    if (bus_if.src_sel[c_sel_zlow])   w_bus = bus_if.zlow_data;
    if (bus_if.src_sel[c_sel_zhigh])  w_bus = bus_if.zhigh_data;
    if (bus_if.src_sel[c_sel_lo])     w_bus = bus_if.lo_data;
    if (bus_if.src_sel[c_sel_hi])     w_bus = bus_if.hi_data;
    for (int k = 15; k >= 0; k--) begin
      if (bus_if.r_out[k]) w_bus = bus_if.r_data[32*k +: 32];
    end
  end

  // --------------------------------------------------------------------------
  // ALU datapath: A = Y register, B = bus
  // --------------------------------------------------------------------------
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic [4:0]         w_sh;
  logic [5:0]         w_sh_inv;
  logic signed [31:0] w_sra;
  logic signed [63:0] w_prod;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [31:0]        w_divisor;
  logic signed [31:0] w_quot;
  logic signed [31:0] w_rem;
  logic [31:0]        w_zlow;
  logic [31:0]        w_zhigh;

  assign w_a      = bus_if.y_data;
  assign w_b      = w_bus;
  assign w_sh     = w_b[4:0];
  // Complementary shift for rotates; a shift of 32 yields 0, which makes a
  // rotate by 0 come out as A unchanged.
  assign w_sh_inv = 6'd32 - {1'b0, w_sh};
  assign w_sra    = $signed(w_a) >>> w_sh;

  // Full signed 64-bit product from explicitly sign-extended operands.
  assign w_prod = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});

  // The divider never sees a zero divisor or the -2^31 / -1 overflow case:
  // both are steered to a divisor of 1. For the overflow case this yields
  // quotient = A (the two's-complement wrapped result) and remainder 0; the
  // zero-divisor case is substituted at the result mux.
  assign w_div_zero = (w_b == 32'd0);
  assign w_div_ovf  = (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
  assign w_divisor  = (w_div_zero || w_div_ovf) ? 32'd1 : w_b;
  assign w_quot     = $signed(w_a) / $signed(w_divisor);
  assign w_rem      = $signed(w_a) % $signed(w_divisor);

  always_comb begin
    w_zlow  = 32'd0;
    w_zhigh = 32'd0;
    case (bus_if.op)
      c_op_ld, c_op_ldi, c_op_st, c_op_add, c_op_addi:
        w_zlow = w_a + w_b;
      c_op_sub:  w_zlow = w_a - w_b;
      c_op_shr:  w_zlow = w_a >> w_sh;
      c_op_shra: w_zlow = w_sra;
      c_op_shl:  w_zlow = w_a << w_sh;
      c_op_ror:  w_zlow = (w_a >> w_sh) | (w_a << w_sh_inv);
      c_op_rol:  w_zlow = (w_a << w_sh) | (w_a >> w_sh_inv);
      c_op_and, c_op_andi: w_zlow = w_a & w_b;
      c_op_or,  c_op_ori:  w_zlow = w_a | w_b;
      c_op_mul: begin
        w_zlow  = w_prod[31:0];
        w_zhigh = w_prod[63:32];
      end
      c_op_div: begin
        if (w_div_zero) begin
          w_zlow  = 32'hFFFF_FFFF;
          w_zhigh = w_a;
        end else begin
          w_zlow  = w_quot;
          w_zhigh = w_rem;
        end
      end
      c_op_neg: w_zlow = 32'd0 - w_b;
      c_op_not: w_zlow = ~w_b;
      default: begin
        w_zlow  = 32'd0;
        w_zhigh = 32'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory data register. The bus sees the registered value, so loading the
  // bus while MDRout is driving it simply recaptures the old contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_mdr <= 32'd0;
    end else if (bus_if.MDRin) begin
      r_mdr <= bus_if.Read ? bus_if.MDataIn : w_bus;
    end
  end

  assign bus_if.BusMuxOut      = w_bus;
  assign bus_if.BusMuxInMDRout = r_mdr;
  assign bus_if.ZLowWire       = w_zlow;
  assign bus_if.ZHighWire      = w_zhigh;

endmodule
`default_nettype wire

// File: tb/tb_alu_bus_mdr.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_bus_mdr
// Description : Self-checking bench for alu_bus_mdr. A behavioural model of
//               the bus, ALU and MDR is compared against the DUT on every
//               falling clock edge; directed vectors additionally pin the
//               outputs to hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_bus_mdr;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  alu_bus_mdr_if bif ();

  alu_bus_mdr dut (
    .clock  (clock),
    .clear  (clear),
    .bus_if (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mdr = 32'd0;   // model MDR contents

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model bus: table of 24 sources in priority order, first asserted wins.
  function automatic logic [31:0] m_bus();
    logic [31:0] val [24];
    logic        sel [24];
    for (int k = 0; k < 16; k++) begin
      val[k] = bif.r_data[32*k +: 32];
      sel[k] = bif.r_out[k];
    end
    val[16] = bif.hi_data;     val[17] = bif.lo_data;
    val[18] = bif.zhigh_data;  val[19] = bif.zlow_data;
    val[20] = bif.pc_data;     val[21] = m_mdr;
    val[22] = bif.inport_data; val[23] = bif.c_data;
    for (int j = 0; j < 8; j++) sel[16+j] = bif.src_sel[j];
    for (int k = 0; k < 24; k++) begin
      if (sel[k]) return val[k];
    end
    return 32'd0;
  endfunction

  // Model ALU using 64-bit integer arithmetic.
  task automatic m_alu(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] opc,
                       output logic [31:0] lo, output logic [31:0] hi);
    longint          sa, sb, sres;
    longint unsigned ua, ures;
    int              s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    s  = int'(b[4:0]);
    ures = 64'd0;
    sres = 64'd0;
    hi = 32'd0;
    case (opc)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: ures = ua + {32'd0, b};
      5'd4:  ures = ua - {32'd0, b};
      5'd5:  ures = ua >> s;
      5'd6:  ures = longint'(sa >>> s);
      5'd7:  ures = ua << s;
      5'd8:  ures = (ua >> s) | (ua << (32 - s));
      5'd9:  ures = (ua << s) | (ua >> (32 - s));
      5'd10, 5'd13: ures = {32'd0, a & b};
      5'd11, 5'd14: ures = {32'd0, a | b};
      5'd15: begin
        sres = sa * sb;
        ures = sres;
        hi   = ures[63:32];
      end
      5'd16: begin
        if (b == 32'd0) begin
          ures = 64'h0000_0000_FFFF_FFFF;
          hi   = a;
        end else begin
          sres = sa / sb;
          ures = sres;
          sres = sa % sb;
          hi   = sres[31:0];
        end
      end
      5'd17: ures = 64'd0 - {32'd0, b};
      5'd18: ures = {32'd0, ~b};
      default: ures = 64'd0;
    endcase
    lo = ures[31:0];
  endtask

  // MDR model: an enabled edge outside clear captures RAM data or the
  // current model bus value. Clear is applied to the model by the stimulus.
  always @(posedge clock) begin
    if (!clear && bif.MDRin) m_mdr = bif.Read ? bif.MDataIn : m_bus();
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clock) begin
    logic [31:0] e_bus, e_lo, e_hi;
    e_bus = m_bus();
    m_alu(bif.y_data, e_bus, bif.op, e_lo, e_hi);
    chk("model_bus",   bif.BusMuxOut,      e_bus);
    chk("model_zlow",  bif.ZLowWire,       e_lo);
    chk("model_zhigh", bif.ZHighWire,      e_hi);
    chk("model_mdr",   bif.BusMuxInMDRout, m_mdr);
  end

  // Advance past one rising edge; inputs change away from both edges.
  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic drive_bus_src(input int sel_bit, input logic [31:0] val);
    bif.r_out   = 16'd0;
    bif.src_sel = 8'd0;
    bif.src_sel[sel_bit] = 1'b1;
    if (sel_bit == 6) bif.inport_data = val;
  endtask

  logic [4:0]  sh_ops [5] = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
  logic [31:0] sh_exp [5] = '{32'h0800_0000, 32'hF800_0000, 32'h0000_0010,
                              32'h1800_0000, 32'h0000_0018};

  initial begin
    clear = 1'b1;
    bif.r_data = '0;   bif.hi_data = '0;  bif.lo_data = '0;
    bif.zhigh_data = '0; bif.zlow_data = '0; bif.pc_data = '0;
    bif.inport_data = '0; bif.c_data = '0;
    bif.r_out = '0;    bif.src_sel = '0;  bif.y_data = '0;
    bif.op = '0;       bif.MDRin = 1'b0;  bif.Read = 1'b0;
    bif.MDataIn = '0;
    settle();
    settle();
    chk("reset_mdr", bif.BusMuxInMDRout, 32'd0);
    chk("reset_bus", bif.BusMuxOut, 32'd0);
    clear = 1'b0;

    // Bus priority
    bif.r_data[3*32 +: 32] = 32'h11;
    bif.hi_data = 32'h22;
    bif.c_data  = 32'hFFFF_FF80;
    bif.r_out[3] = 1'b1;
    bif.src_sel  = 8'b1000_0001;
    #1 chk("prio_r3_over_hi", bif.BusMuxOut, 32'h11);
    settle();
    bif.r_out = '0;
    #1 chk("prio_hi_over_c", bif.BusMuxOut, 32'h22);
    settle();
    bif.src_sel = 8'b1100_0000;
    bif.inport_data = 32'h55;
    #1 chk("prio_inport_over_c", bif.BusMuxOut, 32'h55);
    settle();
    bif.src_sel = '0;
    #1 chk("prio_none", bif.BusMuxOut, 32'd0);
    settle();

    // Add / sub wrap
    drive_bus_src(6, 32'd2);
    bif.y_data = 32'hFFFF_FFFF; bif.op = 5'b00011;
    #1 chk("add_wrap_lo", bif.ZLowWire, 32'h1);
    chk("add_wrap_hi", bif.ZHighWire, 32'h0);
    settle();
    drive_bus_src(6, 32'd1);
    bif.y_data = 32'd0; bif.op = 5'b00100;
    #1 chk("sub_wrap_lo", bif.ZLowWire, 32'hFFFF_FFFF);
    chk("sub_wrap_hi", bif.ZHighWire, 32'h0);
    settle();

    // Shifts and rotates
    drive_bus_src(6, 32'd4);
    bif.y_data = 32'h8000_0001;
    for (int i = 0; i < 5; i++) begin
      bif.op = sh_ops[i];
      #1 chk($sformatf("shift_op%0d", sh_ops[i]), bif.ZLowWire, sh_exp[i]);
      settle();
    end

    // Multiply / divide
    drive_bus_src(6, 32'd7);
    bif.y_data = 32'hFFFF_FFFD; bif.op = 5'b01111;
    #1 chk("mul_hi", bif.ZHighWire, 32'hFFFF_FFFF);
    chk("mul_lo", bif.ZLowWire, 32'hFFFF_FFEB);
    settle();
    drive_bus_src(6, 32'd2);
    bif.y_data = 32'hFFFF_FFF9; bif.op = 5'b10000;
    #1 chk("div_lo", bif.ZLowWire, 32'hFFFF_FFFD);
    chk("div_hi", bif.ZHighWire, 32'hFFFF_FFFF);
    settle();
    drive_bus_src(6, 32'd0);
    #1 chk("div0_lo", bif.ZLowWire, 32'hFFFF_FFFF);
    chk("div0_hi", bif.ZHighWire, 32'hFFFF_FFF9);
    settle();

    // Logic, negate, invert, illegal opcode
    drive_bus_src(6, 32'hFF00_FF00);
    bif.y_data = 32'hF0F0_F0F0; bif.op = 5'b01010;
    #1 chk("and", bif.ZLowWire, 32'hF000_F000);
    settle();
    bif.op = 5'b01110;
    #1 chk("ori", bif.ZLowWire, 32'hFFF0_FFF0);
    settle();
    drive_bus_src(6, 32'd1);
    bif.op = 5'b10001;
    #1 chk("neg", bif.ZLowWire, 32'hFFFF_FFFF);
    settle();
    bif.op = 5'b10010;
    #1 chk("not", bif.ZLowWire, 32'hFFFF_FFFE);
    settle();
    bif.op = 5'b11111;
    #1 chk("illegal_lo", bif.ZLowWire, 32'd0);
    chk("illegal_hi", bif.ZHighWire, 32'd0);
    settle();
    bif.op = 5'b00000;

    // MDR load from RAM
    bif.src_sel = '0;
    bif.Read = 1'b1; bif.MDataIn = 32'hDEAD_BEEF; bif.MDRin = 1'b1;
    settle();
    bif.MDRin = 1'b0;
    #1 chk("mdr_read", bif.BusMuxInMDRout, 32'hDEAD_BEEF);
    // MDR load from bus (R1)
    bif.Read = 1'b0;
    bif.r_data[1*32 +: 32] = 32'h1234;
    bif.r_out = 16'h0002;
    bif.MDRin = 1'b1;
    settle();
    bif.MDRin = 1'b0;
    #1 chk("mdr_bus", bif.BusMuxInMDRout, 32'h1234);
    settle();
    settle();
    chk("mdr_hold", bif.BusMuxInMDRout, 32'h1234);
    // MDR onto the bus, and recapture of its own value
    bif.r_out = '0;
    bif.src_sel = 8'b0010_0000;
    #1 chk("mdr_on_bus", bif.BusMuxOut, 32'h1234);
    bif.MDRin = 1'b1;
    settle();
    bif.MDRin = 1'b0;
    #1 chk("mdr_self", bif.BusMuxInMDRout, 32'h1234);

    // Asynchronous clear between edges; loads ignored while clear is high
    clear = 1'b1;
    m_mdr = 32'd0;
    #1 chk("mdr_clear_async", bif.BusMuxInMDRout, 32'd0);
    bif.Read = 1'b1; bif.MDataIn = 32'h0000_CAFE; bif.MDRin = 1'b1;
    settle();
    chk("mdr_clear_blocks_load", bif.BusMuxInMDRout, 32'd0);
    clear = 1'b0;
    bif.MDRin = 1'b0;
    settle();
    chk("mdr_after_clear", bif.BusMuxInMDRout, 32'd0);
    bif.MDRin = 1'b1;
    settle();
    bif.MDRin = 1'b0;
    #1 chk("mdr_reload", bif.BusMuxInMDRout, 32'h0000_CAFE);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
